full_adder: RTL and testbench
=============================

# full_adder

Full-adder primitive of the 4-bit CPU datapath. It adds two operand bits and a carry-in, producing a sum bit and a carry-out. The WIDTH parameter chains WIDTH full-adder cells as a ripple-carry adder, so the same block serves as the 1-bit cell and as the ALU adder. Outputs are registered on one clock with a synchronous active-low reset, and can be configured combinational.

## Interface
Parameters:
- WIDTH, default 1: operand width in bits; legal range 1..32.
- REGISTERED, default 1: 1 registers sum/c_out/out_valid; 0 makes them combinational from the inputs.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry-in to bit 0.
- in_valid  input  1  qualifies a/b/c_in for capture.
- sum  output  WIDTH  (a + b + c_in) mod 2^WIDTH.
- c_out  output  1  carry out of bit WIDTH-1.
- out_valid  output  1  sum/c_out hold a result.

## Operation
- Per-bit cell i, with carry chain c[0] = c_in:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
  - c_out = c[WIDTH].
- {c_out, sum} equals a + b + c_in exactly, computed at WIDTH+1 bits with no truncation of the carry.
- 1-bit truth table (a b c_in -> c_out sum): 000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11.
- REGISTERED=1:
  - On each rising clk edge with rst_n=1 and in_valid=1: capture the computed sum/c_out and set out_valid=1.
  - With in_valid=0: hold sum/c_out and clear out_valid to 0.
- REGISTERED=0:
  - sum/c_out follow the inputs combinationally; out_valid = in_valid.
  - clk and rst_n are unused.
- X/Z on any input bit is not defined behaviour; the bench drives only 0/1.

## Timing
- REGISTERED=1: latency is 1 cycle from the input-capture edge to the outputs. Throughput is one result per cycle; back-to-back in_valid is legal.
- Reset (REGISTERED=1): when rst_n=0 at a rising edge, sum=0, c_out=0 and out_valid=0 after that edge, regardless of in_valid.
- Reset mid-stream: a transaction presented in the same cycle as rst_n=0 is discarded. The first valid result appears 1 cycle after the first edge with rst_n=1 and in_valid=1.
- Outputs are undefined before the first reset edge; the bench checks only after reset.
- REGISTERED=0: combinational path only, no state.
- Critical path is the WIDTH-deep ripple carry chain; no carry-lookahead is required.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with a=1, b=1, c_in=1, in_valid=1 -> sum=0, c_out=0, out_valid=0 throughout.
- Exhaustive 1-bit (WIDTH=1): apply all 8 combinations of a/b/c_in on consecutive cycles with in_valid=1 -> each result matches the truth table one cycle later. Example: 011 -> c_out=1, sum=0; 111 -> c_out=1, sum=1.
- Hold: drive 101, then in_valid=0 with inputs changed to 000 -> sum=0, c_out=1 held, out_valid=0.
- Wrap (WIDTH=4): a=4'hF, b=4'h0, c_in=1 -> sum=4'h0, c_out=1. Also a=4'h7, b=4'h8, c_in=0 -> sum=4'hF, c_out=0.
- Reset mid-stream (WIDTH=4): a=3, b=4 in the same cycle as rst_n=0 -> out_valid=0 next cycle. Then a=3, b=4, c_in=1 with rst_n=1 -> sum=8, c_out=0.
- Combinational mode (REGISTERED=0, WIDTH=1): step through all 8 input combinations with 10 ns spacing -> outputs match the truth table within the same step, with no clock applied.

Source files
------------

// File: rtl/full_adder.sv
// full_adder: ripple-carry adder cell of the 4-bit CPU datapath.
// WIDTH cells chained; outputs registered or combinational.
module full_adder #(
  parameter int WIDTH      = 1,
  parameter bit REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             out_valid
);

  logic [WIDTH-1:0] s;
  logic             carry;
  logic             co;

  // Ripple the carry through WIDTH full-adder cells, LSB first.
  always_comb begin
    s     = '0;
    carry = c_in;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i])
            | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

  if (REGISTERED) begin : g_reg
    // Capture on valid; hold result and drop valid otherwise.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sum       <= '0;
        c_out     <= 1'b0;
        out_valid <= 1'b0;
      end else if (in_valid) begin
        sum       <= s;
        c_out     <= co;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end else begin : g_comb
    assign sum       = s;
    assign c_out     = co;
    assign out_valid = in_valid;

    // Clock and reset have no role in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
  end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed checks of registered 1/4-bit
// and combinational 1-bit full_adder builds.
module tb_full_adder;

  logic clk = 1'b0;
  logic cclk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // registered, WIDTH=1
  logic rst1_n, a1, b1, c1, v1;
  logic s1, co1, ov1;
  // registered, WIDTH=4
  logic rst4_n, c4, v4;
  logic [3:0] a4, b4, s4;
  logic co4, ov4;
  // combinational, WIDTH=1
  logic ac, bc, cc, vc;
  logic sc, coc, ovc;

  // truth table {c_out,sum} indexed by {a,b,c_in}
  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10,
                         2'b01, 2'b10, 2'b10, 2'b11};

  full_adder #(.WIDTH(1), .REGISTERED(1'b1)) u1 (
    .clk(clk), .rst_n(rst1_n),
    .a(a1), .b(b1), .c_in(c1), .in_valid(v1),
    .sum(s1), .c_out(co1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(4), .REGISTERED(1'b1)) u4 (
    .clk(clk), .rst_n(rst4_n),
    .a(a4), .b(b4), .c_in(c4), .in_valid(v4),
    .sum(s4), .c_out(co4), .out_valid(ov4)
  );

  full_adder #(.WIDTH(1), .REGISTERED(1'b0)) uc (
    .clk(cclk), .rst_n(1'b1),
    .a(ac), .b(bc), .c_in(cc), .in_valid(vc),
    .sum(sc), .c_out(coc), .out_valid(ovc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] a, b;
    logic       c;
    logic [3:0] s;
    logic       co;
  } vec4_t;

  vec4_t v4tab [5] = '{
    '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1},
    '{4'h7, 4'h8, 1'b0, 4'hF, 1'b0},
    '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1},
    '{4'h9, 4'h6, 1'b0, 4'hF, 1'b0},
    '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1}
  };

  initial begin
    rst1_n = 0; a1 = 1; b1 = 1; c1 = 1; v1 = 1;
    rst4_n = 0; a4 = 4'hF; b4 = 4'hF; c4 = 1; v4 = 1;
    ac = 0; bc = 0; cc = 0; vc = 0;

    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("rst_w1_sum", 32'(s1), 32'd0);
      chk("rst_w1_cout", 32'(co1), 32'd0);
      chk("rst_w1_ov", 32'(ov1), 32'd0);
      chk("rst_w4_sum", 32'(s4), 32'd0);
      chk("rst_w4_cout", 32'(co4), 32'd0);
      chk("rst_w4_ov", 32'(ov4), 32'd0);
    end

    rst1_n = 1; rst4_n = 1; v4 = 0;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = 3'(i);
      v1 = 1;
      cyc();
      chk($sformatf("w1_vec%0d", i),
          32'({co1, s1}), 32'(tt[i]));
      chk($sformatf("w1_ov%0d", i),
          32'(ov1), 32'd1);
    end

    {a1, b1, c1} = 3'b101; v1 = 1;
    cyc();
    chk("hold_load", 32'({co1, s1}), 32'b10);
    {a1, b1, c1} = 3'b000; v1 = 0;
    cyc();
    chk("hold_101", 32'({co1, s1}), 32'b10);
    chk("hold_ov", 32'(ov1), 32'd0);
    {a1, b1, c1} = 3'b001; v1 = 1;
    cyc();
    chk("hold2_load", 32'({co1, s1}), 32'b01);
    {a1, b1, c1} = 3'b110; v1 = 0;
    cyc();
    chk("hold_001", 32'({co1, s1}), 32'b01);

    for (int i = 0; i < 5; i++) begin
      a4 = v4tab[i].a; b4 = v4tab[i].b;
      c4 = v4tab[i].c; v4 = 1;
      cyc();
      chk($sformatf("w4_sum%0d", i),
          32'(s4), 32'(v4tab[i].s));
      chk($sformatf("w4_cout%0d", i),
          32'(co4), 32'(v4tab[i].co));
      chk($sformatf("w4_ov%0d", i),
          32'(ov4), 32'd1);
    end

    rst4_n = 0; a4 = 4'd3; b4 = 4'd4; c4 = 0; v4 = 1;
    cyc();
    chk("mid_rst_ov", 32'(ov4), 32'd0);
    chk("mid_rst_sum", 32'(s4), 32'd0);
    rst4_n = 1; a4 = 4'd3; b4 = 4'd4; c4 = 1; v4 = 1;
    cyc();
    chk("post_rst_sum", 32'(s4), 32'd8);
    chk("post_rst_cout", 32'(co4), 32'd0);
    chk("post_rst_ov", 32'(ov4), 32'd1);

    for (int i = 0; i < 8; i++) begin
      {ac, bc, cc} = 3'(i);
      vc = i[0];
      #1;
      chk($sformatf("comb_vec%0d", i),
          32'({coc, sc}), 32'(tt[i]));
      chk($sformatf("comb_ov%0d", i),
          32'(ovc), 32'(i[0]));
      #9;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
